// File: rtl/song_pkg.sv
// Shared types and song tables for the song sequencer: FSM states, ROM entry layout
// and per-song base address / entry count.
package song_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int NUM_SONGS = 3;

  localparam int DUR_MSB  = 11;
  localparam int DUR_LSB  = 8;
  localparam int FREQ_MSB = 7;
  localparam int FREQ_LSB = 0;

  localparam logic [7:0]  FREQ_SILENT  = 8'd0;
  localparam logic [7:0]  PROGRESS_MAX = 8'd100;
  localparam logic [15:0] NOTE_WEIGHT  = 16'd100;

  // Entry 0 is free play: it never reads the ROM, so its base/length are placeholders.
  localparam logic [11:0] SONG_BASE [NUM_SONGS] = '{12'h000, 12'h010, 12'h040};
  localparam logic [15:0] SONG_LEN  [NUM_SONGS] = '{16'd1, 16'd2, 16'd5};

  function automatic logic [3:0] effective_song(input logic [3:0] sel);
    return (int'(sel) < NUM_SONGS) ? sel : 4'd0;
  endfunction

  function automatic logic [11:0] song_base(input logic [3:0] song);
    logic [11:0] base;
    base = '0;
    for (int i = 0; i < NUM_SONGS; i++)
      if (song == 4'(i)) base = SONG_BASE[i];
    return base;
  endfunction

  function automatic logic [15:0] song_len(input logic [3:0] song);
    logic [15:0] len;
    len = 16'd1;
    for (int i = 0; i < NUM_SONGS; i++)
      if (song == 4'(i)) len = SONG_LEN[i];
    return len;
  endfunction

endpackage

// File: rtl/song_sequencer_progress_meter.sv
// Divider-free percentage meter: each finished note adds 100 to an accumulator that is
// drained by song_len once per cycle, bumping the percentage each time.
module progress_meter
  import song_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        force_full,
  input  logic        note_done,
  input  logic [15:0] song_len,
  output logic [7:0]  progress
);

  logic [15:0] acc_q, acc_d;
  logic [7:0]  progress_q, progress_d;

  always_comb begin
    acc_d      = acc_q + (note_done ? NOTE_WEIGHT : 16'd0);
    progress_d = progress_q;
    if (clear) begin
      acc_d      = '0;
      progress_d = '0;
    end else if (force_full) begin
      acc_d      = '0;
      progress_d = PROGRESS_MAX;
    end else if (acc_q >= song_len) begin
      acc_d = acc_d - song_len;
      if (progress_q != PROGRESS_MAX) progress_d = progress_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      progress_q <= '0;
    end else begin
      acc_q      <= acc_d;
      progress_q <= progress_d;
    end
  end

  assign progress = progress_q;

endmodule

// File: rtl/song_sequencer.sv
// Plays a built-in song from an external note ROM, timing each note in beats with a
// silent articulation gap; song 0 passes the live keyboard straight through.
module song_sequencer
  import song_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int ADDR_W      = 12
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [3:0]        iSongSelect,
  input  logic              iStart,
  input  logic              iPause,
  input  logic [7:0]        iKeyFreqType,
  output logic [ADDR_W-1:0] oRomAddr,
  input  logic [11:0]       iRomData,
  output logic [7:0]        oFreqType,
  output logic [7:0]        oProgress,
  output logic [3:0]        oSongSelected,
  output logic              oBusy,
  output logic              oDone
);

  localparam logic [31:0] BEAT_C = 32'(BEAT_CYCLES);
  localparam logic [31:0] GAP_C  = 32'(GAP_CYCLES);

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        freq_q, freq_d;
  logic [3:0]        song_q, song_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort, note_done, prog_clear, prog_full;
  logic [3:0]        rom_dur;

  assign rom_dur = iRomData[DUR_MSB:DUR_LSB];

  // Abort is judged against the incoming selection so the FSM and oSongSelected change together.
  always_comb begin
    song_d     = effective_song(iSongSelect);
    abort      = (song_d != song_q);
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    freq_d     = freq_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    note_done  = 1'b0;
    prog_clear = 1'b0;
    prog_full  = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      prog_clear = 1'b1;
    end else if (iStart && song_q != 4'd0) begin
      state_d    = ST_FETCH;
      addr_d     = ADDR_W'(song_base(song_q));
      busy_d     = 1'b1;
      prog_clear = 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          if (rom_dur == 4'd0) begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            prog_full = 1'b1;
          end else begin
            freq_d  = iRomData[FREQ_MSB:FREQ_LSB];
            cnt_d   = 32'(rom_dur) * BEAT_C - 32'd1;
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!iPause) begin
            if (cnt_q == 32'd0) begin
              note_done = 1'b1;
              addr_d    = addr_q + 1'b1;
              cnt_d     = GAP_C - 32'd1;
              state_d   = ST_GAP;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        ST_GAP: begin
          if (!iPause) begin
            if (cnt_q == 32'd0) state_d = ST_FETCH;
            else                cnt_d   = cnt_q - 32'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      freq_q  <= FREQ_SILENT;
      song_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      freq_q  <= freq_d;
      song_q  <= song_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Tone mux is combinational so free play has no latency and pause mutes immediately.
  always_comb begin
    oFreqType = FREQ_SILENT;
    case (state_q)
      ST_IDLE: if (song_q == 4'd0) oFreqType = iKeyFreqType;
      ST_PLAY: if (!iPause) oFreqType = freq_q;
      default: oFreqType = FREQ_SILENT;
    endcase
  end

  progress_meter u_progress (
    .clk       (iClk),
    .reset     (iReset),
    .clear     (prog_clear),
    .force_full(prog_full),
    .note_done (note_done),
    .song_len  (song_len(song_q)),
    .progress  (oProgress)
  );

  assign oRomAddr      = addr_q;
  assign oSongSelected = song_q;
  assign oBusy         = busy_q;
  assign oDone         = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a short beat/gap and a behavioural 1-cycle ROM
// holding song 1 = {1 beat, 10}, {2 beats, 12}, end marker.
module tb_song_sequencer;

  localparam int ADDR_W = 12;

  logic              iClk = 1'b0;
  logic              iReset;
  logic [3:0]        iSongSelect;
  logic              iStart;
  logic              iPause;
  logic [7:0]        iKeyFreqType;
  logic [ADDR_W-1:0] oRomAddr;
  logic [11:0]       iRomData;
  logic [7:0]        oFreqType;
  logic [7:0]        oProgress;
  logic [3:0]        oSongSelected;
  logic              oBusy;
  logic              oDone;

  logic [11:0] rom_mem [0:4095];

  int checks = 0;
  int errors = 0;

  song_sequencer #(
    .BEAT_CYCLES(4),
    .GAP_CYCLES (2),
    .ADDR_W     (ADDR_W)
  ) dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iSongSelect  (iSongSelect),
    .iStart       (iStart),
    .iPause       (iPause),
    .iKeyFreqType (iKeyFreqType),
    .oRomAddr     (oRomAddr),
    .iRomData     (iRomData),
    .oFreqType    (oFreqType),
    .oProgress    (oProgress),
    .oSongSelected(oSongSelected),
    .oBusy        (oBusy),
    .oDone        (oDone)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) iRomData <= rom_mem[oRomAddr];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  // Full play of song 1, optionally paused for pl cycles starting at cycle ps after the start edge.
  // Silent stretch between notes = 2 gap cycles + fetch + wait.
  task automatic run_song(input string tag, input int ps, input int pl);
    logic [7:0] exp_freq;
    int tone2;
    int dones;
    tone2 = 0;
    dones = 0;
    pulse_start();
    for (int t = 0; t <= 23 + pl; t++) begin
      if (t > 0) tick();
      iPause = (t >= ps && t < ps + pl);
      #1;
      if (iPause)                          exp_freq = 8'd0;
      else if (t >= 2 && t <= 5)           exp_freq = 8'd10;
      else if (t >= 10 && t <= 17 + pl)    exp_freq = 8'd12;
      else                                 exp_freq = 8'd0;
      check({tag, "_freq"}, 16'(oFreqType), 16'(exp_freq));
      check({tag, "_done"}, 16'(oDone), (t == 22 + pl) ? 16'd1 : 16'd0);
      if (oFreqType == 8'd12) tone2++;
      if (oDone) dones++;
      if (t == 0) begin
        check({tag, "_addr0"}, 16'(oRomAddr), 16'h010);
        check({tag, "_prog0"}, 16'(oProgress), 16'd0);
        check({tag, "_busy0"}, 16'(oBusy), 16'd1);
      end
      if (t == 21 + pl) check({tag, "_busy_last"}, 16'(oBusy), 16'd1);
      if (t == 22 + pl) begin
        check({tag, "_busy_end"}, 16'(oBusy), 16'd0);
        check({tag, "_prog_end"}, 16'(oProgress), 16'd100);
      end
    end
    iPause = 1'b0;
    check({tag, "_tone2_cycles"}, 16'(tone2), 16'd8);
    check({tag, "_done_pulses"}, 16'(dones), 16'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (oDone) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 16'(seen), 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 12'h000;
    rom_mem[12'h010] = {4'd1, 8'd10};
    rom_mem[12'h011] = {4'd2, 8'd12};
    rom_mem[12'h012] = 12'h000;

    iReset       = 1'b1;
    iSongSelect  = 4'd0;
    iStart       = 1'b0;
    iPause       = 1'b0;
    iKeyFreqType = 8'd0;
    tick();
    tick();
    check("reset_addr", 16'(oRomAddr), 16'd0);
    check("reset_freq", 16'(oFreqType), 16'd0);
    check("reset_prog", 16'(oProgress), 16'd0);
    check("reset_song", 16'(oSongSelected), 16'd0);
    check("reset_busy", 16'(oBusy), 16'd0);
    check("reset_done", 16'(oDone), 16'd0);
    iReset = 1'b0;

    $display("[TB] song 1 plain play");
    iSongSelect = 4'd1;
    tick();
    tick();
    check("song_sel_1", 16'(oSongSelected), 16'd1);
    run_song("play", 1000, 0);

    $display("[TB] pause 5 cycles during note 2");
    run_song("pause", 12, 5);

    $display("[TB] long pause: progress settles at 50 after note 1");
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    check("lp_note2_freq", 16'(oFreqType), 16'd12);
    iPause = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    check("lp_prog50", 16'(oProgress), 16'd50);
    check("lp_muted", 16'(oFreqType), 16'd0);
    iPause = 1'b0;
    wait_done("lp", 40);
    check("lp_prog100", 16'(oProgress), 16'd100);

    $display("[TB] abort by switching to song 0 during play");
    iKeyFreqType = 8'd23;
    tick();
    pulse_start();
    for (int i = 0; i < 12; i++) tick();
    check("ab_freq_before", 16'(oFreqType), 16'd12);
    check("ab_prog_nonzero", 16'(oProgress != 8'd0), 16'd1);
    iSongSelect = 4'd0;
    tick();
    check("ab_busy", 16'(oBusy), 16'd0);
    check("ab_prog", 16'(oProgress), 16'd0);
    check("ab_song", 16'(oSongSelected), 16'd0);
    check("ab_key23", 16'(oFreqType), 16'd23);
    iKeyFreqType = 8'd5;
    #1;
    check("ab_key5_comb", 16'(oFreqType), 16'd5);
    tick();
    check("ab_key5_hold", 16'(oFreqType), 16'd5);

    $display("[TB] restart during gap of note 1");
    iSongSelect = 4'd1;
    tick();
    tick();
    check("rs_idle_silent", 16'(oFreqType), 16'd0);
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    check("rs_gap_silent", 16'(oFreqType), 16'd0);
    pulse_start();
    check("rs_addr", 16'(oRomAddr), 16'h010);
    check("rs_prog", 16'(oProgress), 16'd0);
    check("rs_busy", 16'(oBusy), 16'd1);
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("rs_replay_freq", 16'(oFreqType), (t >= 2 && t <= 5) ? 16'd10 : 16'd0);
    end
    wait_done("rs", 40);

    $display("[TB] synchronous reset during play");
    iKeyFreqType = 8'd0;
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
    check("rst_playing", 16'(oFreqType), 16'd10);
    iReset = 1'b1;
    tick();
    check("rst_addr", 16'(oRomAddr), 16'd0);
    check("rst_freq", 16'(oFreqType), 16'd0);
    check("rst_prog", 16'(oProgress), 16'd0);
    check("rst_song", 16'(oSongSelected), 16'd0);
    check("rst_busy", 16'(oBusy), 16'd0);
    check("rst_done", 16'(oDone), 16'd0);
    iReset = 1'b0;
    tick();
    tick();
    run_song("after_rst", 1000, 0);

    $display("[TB] out-of-range song select");
    iSongSelect = 4'd9;
    tick();
    tick();
    check("oor_song", 16'(oSongSelected), 16'd0);
    iKeyFreqType = 8'd7;
    pulse_start();
    check("oor_busy", 16'(oBusy), 16'd0);
    check("oor_addr", 16'(oRomAddr), 16'h012);
    check("oor_freq", 16'(oFreqType), 16'd7);
    tick();
    check("oor_busy_later", 16'(oBusy), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
